// File: rtl/slow_control_readback_if.sv
// Serial slow-control chain pins and readout-FIFO write port of the readback block.
// master = readback engine, slave = ASIC chain plus FIFO side.
interface slow_control_readback_if;
  logic       Out_Sr_Ck;
  logic       Out_Sr_In;
  logic       In_Sr_Out;
  logic [7:0] Out_Fifo_Data;
  logic       Out_Fifo_Wr_En;
  logic       In_Fifo_Full;

  modport master (
    output Out_Sr_Ck,
    output Out_Sr_In,
    output Out_Fifo_Data,
    output Out_Fifo_Wr_En,
    input  In_Sr_Out,
    input  In_Fifo_Full
  );

  modport slave (
    input  Out_Sr_Ck,
    input  Out_Sr_In,
    input  Out_Fifo_Data,
    input  Out_Fifo_Wr_En,
    output In_Sr_Out,
    output In_Fifo_Full
  );
endinterface

// File: rtl/slow_control_readback.sv
// SKIROC2 slow-control readback: clocks the chain, recirculates each bit, packs bytes into the FIFO.
// Optional SC_READBACK_CRC_EN appends a CRC-8 (poly 0x07) byte after the last chain byte.
module slow_control_readback #(
  parameter int SC_BITS = 616,
  parameter int CK_LOW  = 3,
  parameter int CK_HIGH = 4
) (
  input  logic Clk,
  input  logic Rst_N,
  input  logic Start_In,
  output logic Busy,
  output logic End_Readback,
  slow_control_readback_if.master sc
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_PUSH = 3'd3,
    ST_TAIL = 3'd4,
    ST_END  = 3'd5
  } state_t;

  localparam logic [7:0] LOW_LAST  = 8'(CK_LOW - 1);
  localparam logic [7:0] LOW_PRE   = 8'(CK_LOW - 2);
  localparam logic [7:0] HIGH_LAST = 8'(CK_HIGH - 1);
  localparam logic [9:0] BITS_END  = 10'(SC_BITS);

  state_t     state_r;
  state_t     state_next_s;
  logic       start_d_r;
  logic       start_edge_s;
  logic [7:0] phase_cnt_r;
  logic [9:0] bit_cnt_r;
  logic [7:0] shift_byte_r;
  logic       sample_s;
  logic       busy_s;
  logic       end_s;
  logic       sr_ck_s;
  logic       sr_in_s;
  logic       wr_en_s;
  logic [7:0] fifo_data_s;

`ifdef SC_READBACK_CRC_EN
  logic [7:0] crc_r;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  assign start_edge_s = Start_In & ~start_d_r;

  // State register
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; PUSH and TAIL hold while the FIFO reports full
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: if (start_edge_s) state_next_s = ST_LOW; else state_next_s = ST_IDLE;
      ST_LOW:  if (phase_cnt_r == LOW_LAST) state_next_s = ST_HIGH; else state_next_s = ST_LOW;
      ST_HIGH: begin
        if (phase_cnt_r == HIGH_LAST) begin
          if (bit_cnt_r[2:0] == 3'd0) state_next_s = ST_PUSH;
          else                        state_next_s = ST_LOW;
        end else begin
          state_next_s = ST_HIGH;
        end
      end
      ST_PUSH: begin
        if (!sc.In_Fifo_Full) begin
          if (bit_cnt_r == BITS_END) state_next_s = ST_TAIL;
          else                       state_next_s = ST_LOW;
        end else begin
          state_next_s = ST_PUSH;
        end
      end
`ifdef SC_READBACK_CRC_EN
      ST_TAIL: if (!sc.In_Fifo_Full) state_next_s = ST_END; else state_next_s = ST_TAIL;
`else
      ST_TAIL: state_next_s = ST_END;
`endif
      ST_END:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode for the coming cycle; sampling one cycle early puts Sr_In on the last LOW cycle
  always_comb begin
    busy_s      = (state_next_s != ST_IDLE) && (state_next_s != ST_END);
    end_s       = (state_next_s == ST_END);
    sr_ck_s     = (state_next_s == ST_HIGH);
    sample_s    = (state_r == ST_LOW) && (state_next_s == ST_LOW) && (phase_cnt_r == LOW_PRE);
    wr_en_s     = 1'b0;
    fifo_data_s = shift_byte_r;
    if (sample_s) begin
      sr_in_s = sc.In_Sr_Out;
    end else if ((state_next_s == ST_IDLE) || (state_next_s == ST_END)) begin
      sr_in_s = 1'b0;
    end else begin
      sr_in_s = sc.Out_Sr_In;
    end
    case (state_r)
      ST_PUSH: begin
        if (!sc.In_Fifo_Full) wr_en_s = 1'b1;
        else                  wr_en_s = 1'b0;
      end
`ifdef SC_READBACK_CRC_EN
      ST_TAIL: begin
        fifo_data_s = crc_r;
        if (!sc.In_Fifo_Full) wr_en_s = 1'b1;
        else                  wr_en_s = 1'b0;
      end
`endif
      default: wr_en_s = 1'b0;
    endcase
  end

  // Edge detector, phase/bit counters and byte assembly
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      start_d_r    <= 1'b0;
      phase_cnt_r  <= 8'd0;
      bit_cnt_r    <= 10'd0;
      shift_byte_r <= 8'd0;
    end else begin
      start_d_r <= Start_In;
      if (state_next_s != state_r) begin
        phase_cnt_r <= 8'd0;
      end else if ((state_r == ST_LOW) || (state_r == ST_HIGH)) begin
        phase_cnt_r <= phase_cnt_r + 8'd1;
      end else begin
        phase_cnt_r <= 8'd0;
      end
      if (state_r == ST_IDLE) begin
        bit_cnt_r <= 10'd0;
      end else if ((state_r == ST_LOW) && (state_next_s == ST_HIGH)) begin
        bit_cnt_r <= bit_cnt_r + 10'd1;
      end
      if (sample_s) begin
        shift_byte_r <= {shift_byte_r[6:0], sc.In_Sr_Out};
      end
    end
  end

`ifdef SC_READBACK_CRC_EN
  // CRC accumulated over every sampled chain bit, MSB first
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      crc_r <= 8'h00;
    end else if (state_r == ST_IDLE) begin
      crc_r <= 8'h00;
    end else if (sample_s) begin
      crc_r <= crc8_step(crc_r, sc.In_Sr_Out);
    end
  end
`endif

  // Registered outputs
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      Busy              <= 1'b0;
      End_Readback      <= 1'b0;
      sc.Out_Sr_Ck      <= 1'b0;
      sc.Out_Sr_In      <= 1'b0;
      sc.Out_Fifo_Wr_En <= 1'b0;
      sc.Out_Fifo_Data  <= 8'h00;
    end else begin
      Busy              <= busy_s;
      End_Readback      <= end_s;
      sc.Out_Sr_Ck      <= sr_ck_s;
      sc.Out_Sr_In      <= sr_in_s;
      sc.Out_Fifo_Wr_En <= wr_en_s;
      if (wr_en_s) begin
        sc.Out_Fifo_Data <= fifo_data_s;
      end
    end
  end

endmodule

// File: tb/tb_slow_control_readback.sv
// Directed bench for slow_control_readback: ASIC chain model, FIFO capture, stall/retrigger/reset cases.
// Build with SC_READBACK_CRC_EN defined to also check the trailing CRC byte.
`timescale 1ns/1ps
module tb_slow_control_readback;
  localparam int SC_BITS = 616;
  localparam int NBYTES  = SC_BITS / 8;
  localparam int CK_LOW  = 3;
  localparam int CK_HIGH = 4;
`ifdef SC_READBACK_CRC_EN
  localparam int NWRITES = NBYTES + 1;
`else
  localparam int NWRITES = NBYTES;
`endif
  localparam int PASS_BUSY = 4390;   // 616*7 + 77 PUSH cycles + 1 TAIL cycle
  localparam int BOUND     = 20000;

  logic Clk;
  logic Rst_N;
  logic Start_In;
  logic Busy;
  logic End_Readback;

  slow_control_readback_if sc ();

  slow_control_readback #(.SC_BITS(SC_BITS), .CK_LOW(CK_LOW), .CK_HIGH(CK_HIGH)) dut (
    .Clk          (Clk),
    .Rst_N        (Rst_N),
    .Start_In     (Start_In),
    .Busy         (Busy),
    .End_Readback (End_Readback),
    .sc           (sc)
  );

  int n_checks, n_errs;
  int cyc, edges, first_edge_cyc, start_cyc;
  int end_cnt, busy_cyc, timing_bad, stall_bad;
  bit stall_mon;
  logic sin_prev;
  logic [7:0] got_q[$];
  logic [7:0] exp_b[NBYTES];
  logic [SC_BITS-1:0] chain, chain_init;

  initial Clk = 1'b0;
  always #100 Clk = ~Clk;

  assign sc.In_Sr_Out = chain[SC_BITS-1];

  always @(posedge Clk) cyc = cyc + 1;

  // ASIC chain: shifts toward the tail on each Sr_Ck rising edge
  always @(posedge sc.Out_Sr_Ck) begin
    if (edges == 0) first_edge_cyc = cyc;
    edges = edges + 1;
    chain <= {chain[SC_BITS-2:0], sc.Out_Sr_In};
  end

  always @(negedge Clk) begin
    if (sc.Out_Fifo_Wr_En === 1'b1) got_q.push_back(sc.Out_Fifo_Data);
    if (End_Readback === 1'b1) end_cnt = end_cnt + 1;
    if (Busy === 1'b1) busy_cyc = busy_cyc + 1;
    if (sc.Out_Sr_Ck === 1'b1 && sc.Out_Sr_In !== sin_prev) timing_bad = timing_bad + 1;
    if (stall_mon && (sc.Out_Fifo_Wr_En !== 1'b0 || sc.Out_Sr_Ck !== 1'b0)) stall_bad = stall_bad + 1;
    sin_prev = sc.Out_Sr_In;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errs = n_errs + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    edges          = 0;
    first_edge_cyc = -1;
    end_cnt        = 0;
    busy_cyc       = 0;
    timing_bad     = 0;
  endtask

  task automatic load_chain(input int mode);
    logic [7:0] b;
    for (int i = 0; i < NBYTES; i++) begin
      case (mode)
        0:       b = 8'h00;
        1:       b = 8'hA5;
        default: b = 8'(i * 7 + 1);
      endcase
      exp_b[i] = b;
      chain[SC_BITS-1-8*i -: 8] = b;
    end
    chain_init = chain;
  endtask

`ifdef SC_READBACK_CRC_EN
  function automatic logic [7:0] crc_model();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      c = c ^ exp_b[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  task automatic start_pulse();
    @(negedge Clk);
    Start_In  = 1'b1;
    start_cyc = cyc + 1;
    @(negedge Clk);
    Start_In  = 1'b0;
  endtask

  task automatic wait_edges(input string tag, input int n);
    int k;
    k = 0;
    while (edges < n && k < BOUND) begin
      @(negedge Clk);
      k++;
    end
    check($sformatf("%s edge_timeout", tag), (k >= BOUND), 0);
  endtask

  task automatic wait_end(input string tag);
    int k;
    k = 0;
    while (End_Readback !== 1'b1 && k < BOUND) begin
      @(negedge Clk);
      k++;
    end
    check($sformatf("%s end_timeout", tag), (k >= BOUND), 0);
    check($sformatf("%s busy_at_end", tag), Busy, 0);
    check($sformatf("%s sr_in_at_end", tag), sc.Out_Sr_In, 0);
    @(negedge Clk);
    check($sformatf("%s end_one_cycle", tag), End_Readback, 0);
  endtask

  task automatic verify_pass(input string tag);
    check($sformatf("%s nwrites", tag), got_q.size(), NWRITES);
    for (int i = 0; i < NBYTES; i++)
      check($sformatf("%s byte%0d", tag, i), (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF, exp_b[i]);
`ifdef SC_READBACK_CRC_EN
    check($sformatf("%s crc", tag), (got_q.size() > NBYTES) ? {24'd0, got_q[NBYTES]} : 32'hFFFF_FFFF, crc_model());
`endif
    check($sformatf("%s edges", tag), edges, SC_BITS);
    check($sformatf("%s end_pulses", tag), end_cnt, 1);
    check($sformatf("%s chain_intact", tag), $countones(chain ^ chain_init), 0);
    check($sformatf("%s sr_in_stability", tag), timing_bad, 0);
  endtask

  initial begin
    int k;
    n_checks = 0; n_errs = 0; cyc = 0; stall_mon = 1'b0; stall_bad = 0; sin_prev = 1'b0;
    Start_In = 1'b0; sc.In_Fifo_Full = 1'b0; Rst_N = 1'b1;
    clear_mon();
    load_chain(1);
    #1 Rst_N = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst busy", Busy, 0);
    check("rst end", End_Readback, 0);
    check("rst sr_ck", sc.Out_Sr_Ck, 0);
    check("rst sr_in", sc.Out_Sr_In, 0);
    check("rst wr_en", sc.Out_Fifo_Wr_En, 0);
    check("rst data", sc.Out_Fifo_Data, 0);
    Rst_N = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle busy", Busy, 0);

    // Plain pass over 0xA5, including latency and length
    clear_mon(); load_chain(1); start_pulse();
    wait_end("a5");
    verify_pass("a5");
    check("a5 first_edge_latency", first_edge_cyc - start_cyc, CK_LOW);
    check("a5 busy_cycles", busy_cyc, PASS_BUSY);

    // FIFO full for 20 cycles while byte 10 is pending
    clear_mon(); load_chain(2); start_pulse();
    wait_edges("stall", 88);
    sc.In_Fifo_Full = 1'b1;
    k = 0;
    while (sc.Out_Sr_Ck !== 1'b0 && k < 50) begin
      @(negedge Clk);
      k++;
    end
    check("stall reach_push", (k >= 50), 0);
    stall_bad = 0; stall_mon = 1'b1;
    repeat (20) @(negedge Clk);
    stall_mon = 1'b0;
    check("stall quiet", stall_bad, 0);
    check("stall bytes_before", got_q.size(), 10);
    check("stall edges_frozen", edges, 88);
    sc.In_Fifo_Full = 1'b0;
    wait_end("stall");
    verify_pass("stall");

    // Start retriggered while busy must be ignored
    clear_mon(); load_chain(1); start_pulse();
    repeat (100) @(negedge Clk);
    Start_In = 1'b1; @(negedge Clk); Start_In = 1'b0;
    repeat (50) @(negedge Clk);
    Start_In = 1'b1; @(negedge Clk); Start_In = 1'b0;
    wait_end("retrig");
    verify_pass("retrig");
    repeat (200) @(negedge Clk);
    check("retrig idle_after", Busy, 0);
    check("retrig single_pass", got_q.size(), NWRITES);

    // Reset in the middle of byte 37
    clear_mon(); load_chain(1); start_pulse();
    wait_edges("midrst", 300);
    Rst_N = 1'b0;
    #20;
    check("midrst busy", Busy, 0);
    check("midrst end", End_Readback, 0);
    check("midrst sr_ck", sc.Out_Sr_Ck, 0);
    check("midrst sr_in", sc.Out_Sr_In, 0);
    check("midrst wr_en", sc.Out_Fifo_Wr_En, 0);
    check("midrst data", sc.Out_Fifo_Data, 0);
    repeat (2) @(negedge Clk);
    Rst_N = 1'b1;
    repeat (20) @(negedge Clk);
    check("midrst idle_after", Busy, 0);
    check("midrst writes", got_q.size(), 37);
    check("midrst edges", edges, 300);

    // All-zero chain after reset recovery
    clear_mon(); load_chain(0); start_pulse();
    wait_end("zero");
    verify_pass("zero");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
